// File: rtl/ht_cmd_ingress.sv
// ht_cmd_ingress: command FIFO in front of the hash table pipeline.
// Sequences the head/data RAM clears before any command is forwarded.
module ht_cmd_ingress #(
    parameter int CMD_W      = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CMD_W-1:0] cmd_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    output logic [CMD_W-1:0] cmd_o,
    output logic             cmd_valid_o,
    input  logic             cmd_ready_i,
    output logic             head_clear_run_o,
    input  logic             head_clear_done_i,
    output logic             data_clear_run_o,
    input  logic             data_clear_done_i,
    input  logic             clear_req_i,
    input  logic             pipeline_idle_i,
    output logic             init_done_o,
    output logic [CNT_W-1:0] fifo_used_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_RESET, S_CLEAR_RUN, S_CLEAR_WAIT, S_READY, S_DRAIN} state_t;

    state_t           r_state, w_next;
    logic [CMD_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_head_done, r_data_done;
    logic             w_empty, w_full, w_push, w_pop, w_both_done;

    assign w_empty          = r_cnt == '0;
    assign w_full           = r_cnt == CNT_W'(FIFO_DEPTH);
    assign cmd_ready_o      = (r_state == S_READY) && !w_full;
    assign cmd_valid_o      = (r_state == S_READY || r_state == S_DRAIN) && !w_empty;
    assign cmd_o            = cmd_valid_o ? r_mem[r_rd_ptr] : '0;
    assign w_push           = cmd_valid_i && cmd_ready_o;
    assign w_pop            = cmd_valid_o && cmd_ready_i;
    assign head_clear_run_o = r_state == S_CLEAR_RUN;
    assign data_clear_run_o = r_state == S_CLEAR_RUN;
    assign init_done_o      = r_state == S_READY;
    assign fifo_used_o      = r_cnt;
    // A done pulse arriving in the same cycle counts as if already latched.
    assign w_both_done      = (r_head_done || head_clear_done_i) && (r_data_done || data_clear_done_i);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET:      w_next = S_CLEAR_RUN;
            S_CLEAR_RUN:  w_next = S_CLEAR_WAIT;
            S_CLEAR_WAIT: w_next = w_both_done ? S_READY : S_CLEAR_WAIT;
            S_READY:      w_next = clear_req_i ? S_DRAIN : S_READY;
            S_DRAIN:      w_next = (w_empty && pipeline_idle_i) ? S_CLEAR_RUN : S_DRAIN;
            default:      w_next = S_RESET;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_RESET;
            r_head_done <= 1'b0;
            r_data_done <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_next;
            r_head_done <= (r_state == S_CLEAR_RUN) ? 1'b0 :
                           (r_state == S_CLEAR_WAIT && head_clear_done_i) ? 1'b1 : r_head_done;
            r_data_done <= (r_state == S_CLEAR_RUN) ? 1'b0 :
                           (r_state == S_CLEAR_WAIT && data_clear_done_i) ? 1'b1 : r_data_done;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_cnt       <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= cmd_i;
    end
endmodule
